rf_read_arbiter: RTL
====================

Name: rf_read_arbiter

Overview:
- Shares the single 8-bit register-file read path (the 8:1 byte mux driven by a 3-bit select) between several requesters, e.g. decode operand A, decode operand B and the debug/monitor port.
- Grants one requester per cycle by round-robin, drives the mux select, captures the mux output and returns it to the granted requester with a valid pulse.
- Sits in the execution block next to the register file, between the register-file mux and its clients.

Parameters:
- NREQ, 3, number of requesters (2..8)
- AW, 3, register address width = mux select width
- DW, 8, data width of the register-file read path

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester read request, level; hold until gnt seen
- addr  input  NREQ*AW  flattened register addresses; requester i uses bits [i*AW +: AW]; stable while req[i] is high
- gnt  output  NREQ  one-hot grant, registered, one-cycle pulse per grant
- sel  output  AW  register-file mux select, registered
- mux_dout  input  DW  register-file mux output (combinational from sel)
- rdata  output  DW  captured read data, registered
- rvalid  output  NREQ  one-hot; rdata is valid for requester i when rvalid[i] is high

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst high at a rising edge): gnt=0, sel=0, rdata=0, rvalid=0, rr_ptr=0. An in-flight grant or response is dropped, with no rvalid for it. Requesters re-request after reset.
- Eligibility in cycle t: req[i]=1 and gnt[i]=0.
  - A requester granted in cycle t cannot win the decision made in t.
  - This prevents a double grant while the requester drops req.
- Arbitration: each cycle, among eligible requesters, pick the first at or after rr_ptr, scanning i=rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
- On a winner w at edge t→t+1:
  - gnt[w]=1 and all other gnt bits 0 in cycle t+1.
  - sel = addr[w] in cycle t+1.
  - rr_ptr = (w+1) mod NREQ; wrap from NREQ-1 to 0.
- No eligible requester: gnt=0 next cycle; sel holds its previous value; rr_ptr unchanged.
- Data capture: at the edge ending cycle t+1, rdata <= mux_dout and rvalid <= gnt. The response is therefore one-hot in cycle t+2.
- Latency: request sampled at t → gnt at t+1 → rvalid/rdata at t+2.
- Throughput: one grant per cycle overall. A single continuously requesting client gets one grant every 2 cycles.
- rdata holds its last value when rvalid=0.
- Requester protocol: drop req, or change addr and keep req for a new read, in the cycle after gnt is seen.
  - Keeping req high means a new request. It is eligible again from cycle t+2.
- Ordering: responses come back in grant order; there is no reordering.
- Simultaneous requests from all clients: served in rr order starting from rr_ptr. No client waits more than NREQ-1 grants (no starvation).
- Register writes in the same cycle as a read: the read returns whatever the mux presents during the gnt cycle. There is no bypass in this block.

Decomposition:
- Shared package/header holds the NREQ, AW and DW defaults and the reset value constants for sel and rr_ptr.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: eligible vector and rr_ptr.
  - Outputs: one-hot winner plus a found flag.
- The top level holds the registers: gnt, sel, rdata, rvalid and rr_ptr.

Test Plan:
- Bench drives register k as 8'h10+k through a behavioural 8:1 mux.
- Reset: hold rst 2 cycles with req=3'b111 → gnt=0, rvalid=0, sel=0, rdata=8'h00 throughout. The first grant appears the cycle after rst falls and goes to requester 0.
- Single read: req[1]=1, addr1=3'd5 at t → gnt=3'b010 and sel=5 at t+1; rvalid=3'b010 and rdata=8'h15 at t+2; nothing further after req drops.
- Full contention: req=3'b111 held continuously, addrs 2/4/7, from reset → grants in order 0,1,2,0,1,2,… with no gaps and no client granted in two consecutive cycles. rdata sequence is 8'h12, 8'h14, 8'h17, repeating.
- Wrap/fairness: rr_ptr=2 after a grant to 1, then req=3'b011 → grant to 0 before 1, and rr_ptr wraps to 1.
- Lone continuous requester: req=3'b100 held → gnt[2] pulses every other cycle, and each rvalid follows its gnt by exactly 1 cycle.
- Reset mid-operation: assert rst in the cycle gnt[0]=1 → no rvalid for that grant, all outputs 0 next cycle, rr_ptr back to 0.

Source files
------------

// File: rtl/rf_read_arbiter_pkg.sv
// Shared defaults and reset values for the register-file read arbiter.
package rf_read_arbiter_pkg;
  localparam int NREQ_DEF   = 3;
  localparam int AW_DEF     = 3;
  localparam int DW_DEF     = 8;
  localparam int SEL_RST    = 0;
  localparam int RR_PTR_RST = 0;
endpackage

// File: rtl/rf_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rf_read_arbiter_rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            found
);

  // Scan offsets k = 0..NREQ-1 from ptr; the first hit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && elig[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin share of the register-file read mux: req at t, gnt/sel at t+1, rvalid/rdata at t+2.
// Backpressure: requesters hold req until gnt; a just-granted requester is skipped for one decision.
module rf_read_arbiter
  import rf_read_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      sel,
  input  logic [DW-1:0]      mux_dout,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    rvalid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win;
  logic            found;
  logic [PW-1:0]   widx;
  logic [AW-1:0]   wsel;
  logic [PW-1:0]   nxt_ptr;

  // A requester holding gnt this cycle is still showing req; mask it out.
  assign elig = req & ~gnt;

  rf_read_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig  (elig),
    .ptr   (rr_ptr),
    .win   (win),
    .found (found)
  );

  always_comb begin
    widx = '0;
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        widx = i[PW-1:0];
        wsel = addr[i*AW +: AW];
      end
    end
    nxt_ptr = (int'(widx) == NREQ - 1) ? '0 : widx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt    <= '0;
      sel    <= AW'(SEL_RST);
      rr_ptr <= PW'(RR_PTR_RST);
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      gnt    <= found ? win : '0;
      rvalid <= gnt;
      if (found) begin
        sel    <= wsel;
        rr_ptr <= nxt_ptr;
      end
      // Mux output reflects sel during the grant cycle; hold rdata otherwise.
      if (|gnt) begin
        rdata <= mux_dout;
      end
    end
  end

endmodule
